serial_display_rx: RTL

SERIAL_DISPLAY_RX -- requirements
Module: serial_display_rx

---
 rtl/serial_display_rx_if.sv | 26 ++
 rtl/serial_display_rx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/serial_display_rx_if.sv
// Bus bundle for serial_display_rx: serial pins from the display driver and the
// decoded per-digit display state that the receiver presents.
interface serial_display_rx_if;
    logic        sclk;
    logic        rclk;
    logic        dio;
    logic [63:0] seg_all;
    logic [31:0] digit_all;
    logic [7:0]  digit_known;
    logic [7:0]  digit_valid;
    logic        frame_stb;
    logic        frame_err;
    logic [7:0]  err_cnt;

    modport master (
        output sclk, rclk, dio,
        input  seg_all, digit_all, digit_known, digit_valid,
        input  frame_stb, frame_err, err_cnt
    );

    modport slave (
        input  sclk, rclk, dio,
        output seg_all, digit_all, digit_known, digit_valid,
        output frame_stb, frame_err, err_cnt
    );
endinterface

// File: rtl/serial_display_rx.sv
// Snoops a 74HC595-style 8-digit 7-segment serial stream and latches per-digit state.
// Define SERIAL_DISPLAY_RX_DECODE_EN to include the segment-to-hex decoder.
module serial_display_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input logic           clk,
    input logic           rst,
    serial_display_rx_if.slave bus
);

    localparam logic [7:0] SEG_BLANK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] rclk_sync;
    logic [SYNC_STAGES-1:0] dio_sync;
    logic                   sclk_prev;
    logic                   rclk_prev;
    logic                   sclk_s;
    logic                   rclk_s;
    logic                   dio_s;
    logic                   sclk_rise;
    logic                   rclk_rise;

    logic [15:0] shreg;
    logic [15:0] shreg_next;
    logic [4:0]  bit_cnt;
    logic [4:0]  bit_cnt_next;
    logic [7:0]  sel;
    logic        sel_onehot;
    logic        accept;
    logic        reject;

    logic [63:0] seg_r;
    logic [7:0]  valid_r;
    logic        stb_r;
    logic        err_r;
    logic [7:0]  err_cnt_r;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign rclk_s    = rclk_sync[SYNC_STAGES-1];
    assign dio_s     = dio_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign rclk_rise = rclk_s & ~rclk_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            rclk_sync <= '0;
            dio_sync  <= '0;
            sclk_prev <= 1'b0;
            rclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            rclk_sync <= {rclk_sync[SYNC_STAGES-2:0], bus.rclk};
            dio_sync  <= {dio_sync[SYNC_STAGES-2:0], bus.dio};
            sclk_prev <= sclk_s;
            rclk_prev <= rclk_s;
        end
    end

    // The latch decision looks at the post-shift view so a shift and a latch
    // landing in the same cycle behave as "shift, then latch".
    always_comb begin
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        if (sclk_rise) begin
            shreg_next = {shreg[14:0], dio_s};
            if (bit_cnt != 5'd31) begin
                bit_cnt_next = bit_cnt + 5'd1;
            end
        end
    end

    assign sel        = shreg_next[7:0];
    assign sel_onehot = (sel != 8'h00) && ((sel & (sel - 8'd1)) == 8'h00);
    assign accept     = rclk_rise && (bit_cnt_next >= 5'd16) && sel_onehot;
    assign reject     = rclk_rise && !accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            seg_r     <= {8{SEG_BLANK}};
            valid_r   <= '0;
            stb_r     <= 1'b0;
            err_r     <= 1'b0;
            err_cnt_r <= '0;
        end else begin
            shreg   <= shreg_next;
            bit_cnt <= rclk_rise ? 5'd0 : bit_cnt_next;
            stb_r   <= accept;
            err_r   <= reject;
            if (reject && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
            if (accept) begin
                for (int i = 0; i < 8; i++) begin
                    if (sel[i]) begin
                        seg_r[8*i +: 8] <= shreg_next[15:8];
                        valid_r[i]      <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SERIAL_DISPLAY_RX_DECODE_EN
    logic [31:0] digit_all_r;
    logic [7:0]  digit_known_r;
    logic [4:0]  dec_result;

    // Returns {known, nibble}; dp is ignored and polarity is normalised first.
    function automatic logic [4:0] decode_glyph(input logic [7:0] seg);
        logic [6:0] g;
        g = SEG_ACTIVE_LOW ? ~seg[6:0] : seg[6:0];
        case (g)
            7'h3F:   decode_glyph = {1'b1, 4'h0};
            7'h06:   decode_glyph = {1'b1, 4'h1};
            7'h5B:   decode_glyph = {1'b1, 4'h2};
            7'h4F:   decode_glyph = {1'b1, 4'h3};
            7'h66:   decode_glyph = {1'b1, 4'h4};
            7'h6D:   decode_glyph = {1'b1, 4'h5};
            7'h7D:   decode_glyph = {1'b1, 4'h6};
            7'h07:   decode_glyph = {1'b1, 4'h7};
            7'h7F:   decode_glyph = {1'b1, 4'h8};
            7'h6F:   decode_glyph = {1'b1, 4'h9};
            7'h77:   decode_glyph = {1'b1, 4'hA};
            7'h7C:   decode_glyph = {1'b1, 4'hB};
            7'h39:   decode_glyph = {1'b1, 4'hC};
            7'h5E:   decode_glyph = {1'b1, 4'hD};
            7'h79:   decode_glyph = {1'b1, 4'hE};
            7'h71:   decode_glyph = {1'b1, 4'hF};
            default: decode_glyph = {1'b0, 4'h0};
        endcase
    endfunction

    assign dec_result = decode_glyph(shreg_next[15:8]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_all_r   <= '0;
            digit_known_r <= '0;
        end else if (accept) begin
            for (int i = 0; i < 8; i++) begin
                if (sel[i]) begin
                    digit_all_r[4*i +: 4] <= dec_result[3:0];
                    digit_known_r[i]      <= dec_result[4];
                end
            end
        end
    end

    assign bus.digit_all   = digit_all_r;
    assign bus.digit_known = digit_known_r;
`else
    assign bus.digit_all   = '0;
    assign bus.digit_known = '0;
`endif

    assign bus.seg_all     = seg_r;
    assign bus.digit_valid = valid_r;
    assign bus.frame_stb   = stb_r;
    assign bus.frame_err   = err_r;
    assign bus.err_cnt     = err_cnt_r;

endmodule
